// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
// Pipelined immediate generator for the ARMv8-subset datapath. Decodes the
// 26-bit instruction immediate field into a DATA_W-bit operand (I, D, CB, B,
// move-wide and shifted-I formats) and queues it in a DEPTH-entry FIFO.
//
// Ports:
//   CLK            rising-edge clock
//   resetl         synchronous active-low reset
//   in_valid       request present
//   in_ready       block can accept a request this cycle
//   in_instr[25:0] instruction immediate bits
//   in_op[2:0]     format select
//   out_valid      head FIFO entry valid
//   out_ready      consumer takes the head entry this cycle
//   out_imm        immediate of the head entry (0 when out_valid = 0)
//   out_illegal    head entry came from an illegal request (0 when empty)
//   illegal_count  saturating count of accepted illegal requests
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 2,
   parameter int CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              resetl,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [25:0]       in_instr,
   input  logic [2:0]        in_op,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_imm,
   output logic              out_illegal,
   output logic [CNT_W-1:0]  illegal_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] C_DEPTH = (PTR_W+1)'(DEPTH);

   logic [DATA_W-1:0] r_mem_imm [DEPTH];
   logic              r_mem_ill [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W:0]    r_count;
   logic [CNT_W-1:0]  r_ill_cnt;

   logic [63:0]       w_imm64;
   logic [DATA_W-1:0] w_imm;
   logic              w_ill;
   logic              w_push;
   logic              w_pop;

   // Format 11x is never defined; a move-wide with hw >= 2 cannot place its
   // halfword inside a 32-bit result (hw >= 2 is exactly instr[22] = 1).
   assign w_ill = (in_op[2:1] == 2'b11) ||
                  ((in_op == 3'b100) && (DATA_W == 32) && in_instr[22]);

   // Everything is built at 64 bits and then truncated, so the 32-bit B
   // result keeps the low half of the full sign extension.
   always_comb begin
      w_imm64 = '0;
      case (in_op)
         3'b000: w_imm64 = {52'b0, in_instr[21:10]};
         3'b001: w_imm64 = {{55{in_instr[20]}}, in_instr[20:12]};
         3'b010: w_imm64 = {{43{in_instr[23]}}, in_instr[23:5], 2'b00};
         3'b011: w_imm64 = {{36{in_instr[25]}}, in_instr[25:0], 2'b00};
         3'b100: w_imm64 = {48'b0, in_instr[20:5]} << {in_instr[22:21], 4'b0000};
         3'b101: w_imm64 = in_instr[22] ? {40'b0, in_instr[21:10], 12'b0}
                                        : {52'b0, in_instr[21:10]};
         default: w_imm64 = '0;
      endcase
      if (w_ill) begin
         w_imm64 = '0;
      end
   end

   assign w_imm = w_imm64[DATA_W-1:0];

   // Ready looks only at the registered count: a full FIFO refuses a push
   // even in a cycle where the head is popped.
   assign in_ready  = resetl && (r_count < C_DEPTH);
   assign out_valid = (r_count != '0);
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

   assign out_imm       = out_valid ? r_mem_imm[r_rd_ptr] : '0;
   assign out_illegal   = out_valid ? r_mem_ill[r_rd_ptr] : 1'b0;
   assign illegal_count = r_ill_cnt;

   // Storage holds no reset: stale entries are invisible once count is 0.
   always_ff @(posedge CLK) begin
      if (w_push) begin
         r_mem_imm[r_wr_ptr] <= w_imm;
         r_mem_ill[r_wr_ptr] <= w_ill;
      end
   end

   always_ff @(posedge CLK) begin
      if (!resetl) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_ill_cnt <= '0;
      end else begin
         // DEPTH is a power of two, so natural pointer overflow wraps mod DEPTH.
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_push && w_pop) begin
            r_count <= r_count - 1'b1;
         end
         if (w_push && w_ill && (r_ill_cnt != '1)) begin
            r_ill_cnt <= r_ill_cnt + 1'b1;
         end
      end
   end

endmodule
